// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch sequencer for the RV32I core.
// Fetches over a valid/ack memory handshake and hands words to decode over valid/ready.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] pc_seq,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t state;
  logic   drop;
  logic   bad_target;

  assign bad_target  = (redirect_target[1:0] != 2'b00);
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == VALID);
  assign imem_addr   = pc;

  // drop remembers that the response now in flight belongs to a PC abandoned by a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      instr      <= 32'h0;
      instr_pc   <= 32'h0;
      misaligned <= 1'b0;
      drop       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect) begin
            pc <= redirect_target;
            if (bad_target) begin
              misaligned <= 1'b1;
              state      <= TRAP;
            end
          end
        end
        FETCH: begin
          if (redirect && bad_target) begin
            pc         <= redirect_target;
            misaligned <= 1'b1;
            state      <= TRAP;
          end else if (redirect) begin
            pc   <= redirect_target;
            drop <= !imem_ack;
          end else if (imem_ack) begin
            if (drop) begin
              drop <= 1'b0;
            end else begin
              instr    <= imem_rdata;
              instr_pc <= pc;
              state    <= VALID;
            end
          end
        end
        VALID: begin
          if (redirect) begin
            pc <= redirect_target;
            if (bad_target) begin
              misaligned <= 1'b1;
              state      <= TRAP;
            end else begin
              state <= FETCH;
            end
          end else if (instr_ready) begin
            pc    <= pc_seq;
            state <= FETCH;
          end
        end
        TRAP: begin
          // Frozen until reset; any late memory response is simply ignored.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized run
// scored against a delivered-instruction model (next PC = last redirect target or previous + 4).
module tb_fetch_pc_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        misaligned;

  int vectors;
  int miscompares;

  int          mem_waits;
  int          mem_cnt;
  logic [31:0] mem_addr_lat;
  bit          mem_rand;

  fetch_pc_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_seq(pc_seq),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .misaligned(misaligned)
  );

  // The external adder.
  assign pc_seq = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: latches the address when a request starts and answers after mem_waits cycles.
  task automatic mem_cycle();
    if (imem_req) begin
      if (mem_cnt == 0) begin
        mem_addr_lat = imem_addr;
        if (mem_rand) mem_waits = $urandom_range(0, 3);
      end
      if (mem_cnt >= mem_waits) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_addr_lat ^ KEY;
        mem_cnt    = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom();
        mem_cnt    = mem_cnt + 1;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom();
      mem_cnt    = 0;
    end
  endtask

  task automatic step();
    mem_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    redirect_target = 32'h0;
    instr_ready = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    mem_cnt = 0;
    mem_waits = 0;
    mem_rand = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (!instr_valid) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: instr_valid=%b after %0d cycles, required 1", name, instr_valid, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({pc, instr, instr_pc} !== 96'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: pc=%h instr=%h instr_pc=%h, required all 0", pc, instr, instr_pc);
    end
    vectors++;
    if ({instr_valid, imem_req, misaligned} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: valid/req/mis=%b, required 000", {instr_valid, imem_req, misaligned});
    end
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_req: imem_req=%b, required 0", imem_req);
    end
    step();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL first_req: req=%b addr=%h, required 1 / 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    logic        exp_valid;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(5, "seq");
    exp = 32'h0;
    exp_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (instr_valid !== exp_valid) begin
        miscompares++;
        $display("[TB] FAIL seq_valid_%0d: instr_valid=%b, required %b", i, instr_valid, exp_valid);
      end
      if (exp_valid) begin
        vectors++;
        if (instr_pc !== exp || instr !== (exp ^ KEY)) begin
          miscompares++;
          $display("[TB] FAIL seq_word_%0d: instr_pc=%h instr=%h, required %h / %h", i, instr_pc, instr, exp, exp ^ KEY);
        end
        exp = exp + 32'd4;
      end
      exp_valid = !exp_valid;
      step();
    end
  endtask

  task automatic test_wait_redirect();
    do_reset();
    mem_waits = 3;
    instr_ready = 1'b1;
    step();
    step();
    redirect = 1'b1;
    redirect_target = 32'h100;
    step();
    redirect = 1'b0;
    wait_valid(20, "drop");
    vectors++;
    if (instr_pc !== 32'h100 || instr !== (32'h100 ^ KEY)) begin
      miscompares++;
      $display("[TB] FAIL drop_word: instr_pc=%h instr=%h, required 00000100 / %h", instr_pc, instr, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    do_reset();
    instr_ready = 1'b0;
    wait_valid(5, "stall");
    held_instr = instr;
    held_pc = instr_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (instr !== held_instr || instr_pc !== held_pc || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold_%0d: instr=%h pc=%h valid=%b req=%b, required %h %h 1 0",
                 i, instr, instr_pc, instr_valid, imem_req, held_instr, held_pc);
      end
    end
    redirect = 1'b1;
    redirect_target = 32'h40;
    instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_redirect: req=%b addr=%h valid=%b, required 1 00000040 0", imem_req, imem_addr, instr_valid);
    end
    wait_valid(5, "stall2");
    vectors++;
    if (instr_pc !== 32'h40) begin
      miscompares++;
      $display("[TB] FAIL stall_next: instr_pc=%h, required 00000040", instr_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1'b1;
    step();
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    wait_valid(5, "wrap");
    vectors++;
    if (instr_pc !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("[TB] FAIL wrap_pc: instr_pc=%h, required fffffffc", instr_pc);
    end
    step();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL wrap_addr: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    mem_waits = 2;
    instr_ready = 1'b0;
    step();
    redirect = 1'b1;
    redirect_target = 32'h102;
    step();
    redirect = 1'b0;
    vectors++;
    if (misaligned !== 1'b1 || pc !== 32'h102 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL trap_entry: mis=%b pc=%h req=%b valid=%b, required 1 00000102 0 0", misaligned, pc, imem_req, instr_valid);
    end
    for (int i = 0; i < 10; i++) begin
      redirect = $urandom_range(0, 1);
      redirect_target = $urandom() & 32'hFFFF_FFFC;
      instr_ready = $urandom_range(0, 1);
      imem_ack = $urandom_range(0, 1);
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (misaligned !== 1'b1 || pc !== 32'h102 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL trap_hold_%0d: mis=%b pc=%h req=%b valid=%b, required 1 00000102 0 0", i, misaligned, pc, imem_req, instr_valid);
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_reset_midvalid();
    do_reset();
    instr_ready = 1'b1;
    step();
    step();
    step();
    step();
    instr_ready = 1'b0;
    wait_valid(5, "rstmid");
    rst = 1'b1;
    #1;
    vectors++;
    if ({pc, instr, instr_pc} !== 96'h0 || {instr_valid, imem_req, misaligned} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL async_reset: pc=%h instr=%h instr_pc=%h flags=%b, required zeros",
               pc, instr, instr_pc, {instr_valid, imem_req, misaligned});
    end
    @(negedge clk);
    rst = 1'b0;
    mem_cnt = 0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart: req=%b addr=%h valid=%b, required 1 00000000 0", imem_req, imem_addr, instr_valid);
    end
    wait_valid(5, "restart");
    vectors++;
    if (instr_pc !== 32'h0 || instr !== KEY) begin
      miscompares++;
      $display("[TB] FAIL restart_word: instr_pc=%h instr=%h, required 00000000 / %h", instr_pc, instr, KEY);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int          delivered;
    do_reset();
    mem_rand = 1'b1;
    exp_pc = 32'h0;
    delivered = 0;
    for (int i = 0; i < 600; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom() & 32'hFFFF_FFFC;
      vectors++;
      if (imem_addr !== pc || (imem_req && instr_valid) || misaligned !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rand_invariant_%0d: addr=%h pc=%h req=%b valid=%b mis=%b, required addr==pc, not both, mis 0",
                 i, imem_addr, pc, imem_req, instr_valid, misaligned);
      end
      if (instr_valid && instr_ready && !redirect) begin
        vectors++;
        if (instr_pc !== exp_pc || instr !== (exp_pc ^ KEY)) begin
          miscompares++;
          $display("[TB] FAIL rand_deliver_%0d: instr_pc=%h instr=%h, required %h / %h", i, instr_pc, instr, exp_pc, exp_pc ^ KEY);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redirect) exp_pc = redirect_target;
      step();
    end
    redirect = 1'b0;
    mem_rand = 1'b0;
    vectors++;
    if (delivered < 20) begin
      miscompares++;
      $display("[TB] FAIL rand_progress: delivered=%0d, required at least 20", delivered);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    test_reset();
    test_sequential();
    test_wait_redirect();
    test_stall_redirect();
    test_wrap();
    test_misaligned();
    test_reset_midvalid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
